// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: stage-bit positions, strobe masks and
// hazard-sequencer FSM encodings.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned STG_PC    = 0;
    localparam int unsigned STG_IFID  = 1;
    localparam int unsigned STG_IDEX  = 2;
    localparam int unsigned STG_EXMEM = 3;
    localparam int unsigned STG_MEMWB = 4;
    localparam int unsigned NUM_STG   = 5;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StMcWait = 2'd1,
        StFlush  = 2'd2
    } hz_state_e;

    function automatic logic [NUM_STG-1:0] stg_bit(input int unsigned stg);
        return NUM_STG'(1) << stg;
    endfunction

    // Multi-cycle hold keeps pc..id_ex and bubbles ex_mem; load-use bubbles id_ex.
    localparam logic [NUM_STG-1:0] STALL_MC   = stg_bit(STG_PC) | stg_bit(STG_IFID)
                                              | stg_bit(STG_IDEX);
    localparam logic [NUM_STG-1:0] FLUSH_MC   = stg_bit(STG_EXMEM);
    localparam logic [NUM_STG-1:0] STALL_LU   = stg_bit(STG_PC) | stg_bit(STG_IFID);
    localparam logic [NUM_STG-1:0] FLUSH_LU   = stg_bit(STG_IDEX);
    localparam logic [NUM_STG-1:0] FLUSH_BR   = stg_bit(STG_IFID) | stg_bit(STG_IDEX);
    localparam logic [NUM_STG-1:0] FLUSH_IFID = stg_bit(STG_IFID);
    localparam logic [NUM_STG-1:0] ALL_STG    = FLUSH_BR | STALL_MC | FLUSH_MC
                                              | stg_bit(STG_MEMWB);

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for perf statistics.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: load-use detection, multi-cycle EX hold with
// timeout, and wrong-path squash after taken branches.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned MC_TMO    = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_re1,
    input  logic [4:0]       id_rs1,
    input  logic             id_re2,
    input  logic [4:0]       id_rs2,
    input  logic             ex_wreg,
    input  logic [4:0]       ex_wd,
    input  logic             ex_is_load,
    input  logic             ex_mc_req,
    input  logic             ex_mc_done,
    input  logic             ex_br_taken,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic [1:0]       state_o,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned TMO_W = $clog2(MC_TMO + 1);
    localparam int unsigned FL_W  = $clog2(FLUSH_CYC + 1);

    hz_state_e        state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [FL_W-1:0]  fl_q, fl_d;
    logic             load_use;
    logic             flush_ev;

    // x0 is never a real destination, so it cannot create a hazard.
    assign load_use = ex_is_load && ex_wreg && (ex_wd != 5'd0) &&
                      ((id_re1 && (id_rs1 == ex_wd)) || (id_re2 && (id_rs2 == ex_wd)));

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        fl_d       = fl_q;
        stall      = '0;
        flush      = '0;
        mc_timeout = 1'b0;
        flush_ev   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (ex_br_taken) begin
                    flush    = FLUSH_BR;
                    flush_ev = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = StFlush;
                        fl_d    = FL_W'(FLUSH_CYC - 1);
                    end
                end else if (ex_mc_req && !ex_mc_done) begin
                    stall   = STALL_MC;
                    flush   = FLUSH_MC;
                    state_d = StMcWait;
                    tmo_d   = TMO_W'(1);
                end else if (load_use) begin
                    stall = STALL_LU;
                    flush = FLUSH_LU;
                end
            end
            StMcWait: begin
                if (ex_mc_done) begin
                    state_d = StRun;
                end else if (tmo_q == TMO_W'(MC_TMO)) begin
                    mc_timeout = 1'b1;
                    state_d    = StRun;
                end else begin
                    stall = STALL_MC;
                    flush = FLUSH_MC;
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StFlush: begin
                if (ex_br_taken) begin
                    flush    = FLUSH_BR;
                    flush_ev = 1'b1;
                    fl_d     = FL_W'(FLUSH_CYC - 1);
                end else begin
                    flush = FLUSH_IFID;
                    if (fl_q == FL_W'(1)) begin
                        state_d = StRun;
                    end else begin
                        fl_d = fl_q - 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            tmo_q   <= '0;
            fl_q    <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            fl_q    <= fl_d;
        end
    end

    assign state_o = state_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (|stall),
        .clr  (1'b0),
        .q    (stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (flush_ev),
        .clr  (1'b0),
        .q    (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two configurations share one stimulus stream; expected
// values are queued per cycle and checked by an independent negedge monitor.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_re1, id_re2, ex_wreg, ex_is_load, ex_mc_req, ex_mc_done, ex_br_taken;
    logic [4:0] id_rs1, id_rs2, ex_wd;

    logic [4:0]  a_stall, a_flush, b_stall, b_flush;
    logic [1:0]  a_state, b_state;
    logic        a_tmo, b_tmo;
    logic [15:0] a_scnt, a_fcnt;
    logic [3:0]  b_scnt, b_fcnt;

    // A: FLUSH_CYC=3, MC_TMO=64, CNT_W=16.  B: FLUSH_CYC=1, MC_TMO=8, CNT_W=4.
    pipe_hazard_ctrl #(.FLUSH_CYC(3), .MC_TMO(64), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_re1(id_re1), .id_rs1(id_rs1), .id_re2(id_re2),
        .id_rs2(id_rs2), .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
        .ex_mc_req(ex_mc_req), .ex_mc_done(ex_mc_done), .ex_br_taken(ex_br_taken),
        .stall(a_stall), .flush(a_flush), .state_o(a_state), .mc_timeout(a_tmo),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    pipe_hazard_ctrl #(.FLUSH_CYC(1), .MC_TMO(8), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_re1(id_re1), .id_rs1(id_rs1), .id_re2(id_re2),
        .id_rs2(id_rs2), .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
        .ex_mc_req(ex_mc_req), .ex_mc_done(ex_mc_done), .ex_br_taken(ex_br_taken),
        .stall(b_stall), .flush(b_flush), .state_o(b_state), .mc_timeout(b_tmo),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    typedef struct {
        string name;
        int    cyc;
        int    dut;
        int    fld;
        int    val;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_vec;
    int   n_bad;

    localparam int F_STALL = 0, F_FLUSH = 1, F_STATE = 2, F_TMO = 3, F_SCNT = 4, F_FCNT = 5;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    function automatic int actual(input int dut, input int fld);
        if (dut == 0) begin
            case (fld)
                F_STALL: return int'(a_stall);
                F_FLUSH: return int'(a_flush);
                F_STATE: return int'(a_state);
                F_TMO:   return int'(a_tmo);
                F_SCNT:  return int'(a_scnt);
                default: return int'(a_fcnt);
            endcase
        end
        case (fld)
            F_STALL: return int'(b_stall);
            F_FLUSH: return int'(b_flush);
            F_STATE: return int'(b_state);
            F_TMO:   return int'(b_tmo);
            F_SCNT:  return int'(b_scnt);
            default: return int'(b_fcnt);
        endcase
    endfunction

    // Monitor: pops every expectation due this cycle and compares at negedge.
    initial begin
        exp_t e;
        int   act;
        n_vec = 0;
        n_bad = 0;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e   = q.pop_front();
                act = actual(e.dut, e.fld);
                n_vec++;
                if (e.cyc != cyc || act != e.val) begin
                    n_bad++;
                    $display("FAIL %s dut%0d fld%0d cyc%0d: got %0d, want %0d (due cyc %0d)",
                             e.name, e.dut, e.fld, cyc, act, e.val, e.cyc);
                end
            end
        end
    end

    task automatic push(input string name, input int dut, input int fld, input int val,
                        input int dly);
        exp_t e;
        e.name = name;
        e.cyc  = cyc + dly;
        e.dut  = dut;
        e.fld  = fld;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic chk_out(input string name, input int dut, input int st, input int fl,
                           input int s);
        push(name, dut, F_STALL, st, 0);
        push(name, dut, F_FLUSH, fl, 0);
        push(name, dut, F_STATE, s, 0);
    endtask

    task automatic chk_cnt(input string name, input int sa, input int sb, input int fa,
                           input int fb, input int dly);
        push(name, 0, F_SCNT, sa, dly);
        push(name, 1, F_SCNT, sb, dly);
        push(name, 0, F_FCNT, fa, dly);
        push(name, 1, F_FCNT, fb, dly);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_re1 = 0; id_rs1 = 0; id_re2 = 0; id_rs2 = 0;
        ex_wreg = 0; ex_wd = 0; ex_is_load = 0;
        ex_mc_req = 0; ex_mc_done = 0; ex_br_taken = 0;
    endtask

    task automatic lu_rs1();
        ex_is_load = 1; ex_wreg = 1; ex_wd = 5'd5; id_re1 = 1; id_rs1 = 5'd5;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        chk_out("reset", 0, 0, 0, 0);
        chk_out("reset", 1, 0, 0, 0);
        push("reset_tmo", 0, F_TMO, 0, 0);
        push("reset_tmo", 1, F_TMO, 0, 0);
        chk_cnt("reset_cnt", 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;

        // Load-use on rs1, then on rs2, then disabled read port, then x0.
        tick(); idle(); lu_rs1();
        chk_out("lu_rs1", 0, 3, 4, 0); chk_out("lu_rs1", 1, 3, 4, 0);
        tick(); idle();
        chk_out("lu_after", 0, 0, 0, 0); chk_out("lu_after", 1, 0, 0, 0);
        chk_cnt("lu_cnt1", 1, 1, 0, 0, 0);
        tick(); idle();
        ex_is_load = 1; ex_wreg = 1; ex_wd = 5'd5; id_rs1 = 5'd5; id_re2 = 1; id_rs2 = 5'd5;
        chk_out("lu_rs2", 0, 3, 4, 0); chk_out("lu_rs2", 1, 3, 4, 0);
        tick(); idle();
        ex_is_load = 1; ex_wreg = 1; ex_wd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd5;
        chk_out("lu_noread", 0, 0, 0, 0); chk_out("lu_noread", 1, 0, 0, 0);
        chk_cnt("lu_cnt2", 2, 2, 0, 0, 0);
        tick(); idle();
        ex_is_load = 1; ex_wreg = 1; ex_wd = 5'd0; id_re1 = 1; id_re2 = 1;
        chk_out("lu_x0", 0, 0, 0, 0); chk_out("lu_x0", 1, 0, 0, 0);

        // Multi-cycle op: A waits for done at cycle 33, B times out at wait 8.
        for (int i = 1; i <= 34; i++) begin
            tick(); idle();
            if (i == 1) ex_mc_req = 1;
            if (i == 20) ex_br_taken = 1;
            if (i == 21) lu_rs1();
            if (i == 33) begin ex_mc_req = 1; ex_mc_done = 1; end
            if (i <= 32) chk_out("mc_a", 0, 7, 8, (i == 1) ? 0 : 1);
            else if (i == 33) chk_out("mc_a_done", 0, 0, 0, 1);
            else chk_out("mc_a_end", 0, 0, 0, 0);
            push("mc_a_tmo", 0, F_TMO, 0, 0);
            if (i <= 8) chk_out("mc_b", 1, 7, 8, (i == 1) ? 0 : 1);
            else if (i == 9) chk_out("mc_b_tmo", 1, 0, 0, 1);
            else if (i == 20) chk_out("mc_b_br", 1, 0, 6, 0);
            else if (i == 21) chk_out("mc_b_lu", 1, 3, 4, 0);
            else chk_out("mc_b_run", 1, 0, 0, 0);
            push("mc_b_tmo", 1, F_TMO, (i == 9) ? 1 : 0, 0);
        end
        chk_cnt("mc_cnt", 34, 11, 0, 1, 0);

        // Single taken branch.
        for (int i = 1; i <= 4; i++) begin
            tick(); idle();
            if (i == 1) ex_br_taken = 1;
            case (i)
                1:       chk_out("br1_a", 0, 0, 6, 0);
                2, 3:    chk_out("br1_a", 0, 0, 2, 2);
                default: chk_out("br1_a", 0, 0, 0, 0);
            endcase
            chk_out("br1_b", 1, 0, (i == 1) ? 6 : 0, 0);
        end
        chk_cnt("br1_cnt", 34, 11, 1, 2, 0);

        // Second branch inside the flush window restarts the count.
        for (int i = 1; i <= 6; i++) begin
            tick(); idle();
            if (i == 1 || i == 3) ex_br_taken = 1;
            case (i)
                1:       chk_out("br2_a", 0, 0, 6, 0);
                3:       chk_out("br2_a", 0, 0, 6, 2);
                2, 4, 5: chk_out("br2_a", 0, 0, 2, 2);
                default: chk_out("br2_a", 0, 0, 0, 0);
            endcase
            chk_out("br2_b", 1, 0, (i == 1 || i == 3) ? 6 : 0, 0);
        end
        chk_cnt("br2_cnt", 34, 11, 3, 4, 0);

        // Priority: branch beats mc_req and load-use; mc_req beats load-use.
        for (int i = 1; i <= 7; i++) begin
            tick(); idle();
            if (i == 1) begin ex_br_taken = 1; ex_mc_req = 1; lu_rs1(); end
            if (i == 5) begin ex_mc_req = 1; lu_rs1(); end
            if (i == 6) ex_mc_done = 1;
            case (i)
                1:       chk_out("prio_a", 0, 0, 6, 0);
                2, 3:    chk_out("prio_a", 0, 0, 2, 2);
                5:       chk_out("prio_a", 0, 7, 8, 0);
                6:       chk_out("prio_a", 0, 0, 0, 1);
                default: chk_out("prio_a", 0, 0, 0, 0);
            endcase
            case (i)
                1:       chk_out("prio_b", 1, 0, 6, 0);
                5:       chk_out("prio_b", 1, 7, 8, 0);
                6:       chk_out("prio_b", 1, 0, 0, 1);
                default: chk_out("prio_b", 1, 0, 0, 0);
            endcase
        end
        chk_cnt("prio_cnt", 35, 12, 4, 5, 0);

        // Asynchronous reset in the middle of MC_WAIT.
        tick(); idle(); ex_mc_req = 1;
        tick(); idle();
        chk_out("rst_pre", 0, 7, 8, 1); chk_out("rst_pre", 1, 7, 8, 1);
        tick(); idle(); rst_n = 1'b0;
        chk_out("rst_async", 0, 0, 0, 0); chk_out("rst_async", 1, 0, 0, 0);
        chk_cnt("rst_cnt", 0, 0, 0, 0, 0);
        tick(); rst_n = 1'b1;
        chk_out("rst_rel", 0, 0, 0, 0); chk_out("rst_rel", 1, 0, 0, 0);

        // Continuous load-use stall for 2^4+5 cycles: B saturates at 15.
        for (int i = 0; i < 21; i++) begin
            tick(); idle(); lu_rs1();
            push("sat_stall", 0, F_STALL, 3, 0);
            push("sat_stall", 1, F_STALL, 3, 0);
            push("sat_a", 0, F_SCNT, i + 1, 1);
            push("sat_b", 1, F_SCNT, (i + 1 > 15) ? 15 : i + 1, 1);
        end
        tick(); idle();
        tick();
        tick();
        if (q.size() != 0) begin
            n_bad += q.size();
            $display("FAIL undrained: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
